// File: rtl/segment_display_sched.sv
// segment_display_sched: time-shares the two-digit segment display between
// CH_NUM 8-bit count sources, round-robin with update pre-emption.
// Ports: clk_in, rst_in (async, active-high); ch_en_in, ch_data_in and
// ch_upd_in per channel; count_out, ch_sel_out, valid_out, switch_out (all registered).
module segment_display_sched #(
    parameter int CH_NUM       = 4,
    parameter int DWELL_CYCLES = 12_000_000,
    parameter int MIN_DWELL    = 3_000_000,
    localparam int SEL_W       = $clog2(CH_NUM)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [CH_NUM-1:0]   ch_en_in,
    input  logic [8*CH_NUM-1:0] ch_data_in,
    input  logic [CH_NUM-1:0]   ch_upd_in,
    output logic [7:0]          count_out,
    output logic [SEL_W-1:0]    ch_sel_out,
    output logic                valid_out,
    output logic                switch_out
);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0]    MIN_LAST   = DW'(MIN_DWELL - 1);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CH_NUM - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state;
    logic [DW-1:0]     dwell_cnt;
    logic [CH_NUM-1:0] pending;
    logic [7:0]        ch_data [CH_NUM];
    logic [SEL_W-1:0]  cur;
    logic [SEL_W-1:0]  nxt;
    logic [SEL_W-1:0]  idx;
    logic              found;
    logic [CH_NUM-1:0] cand;
    logic              any_en;
    logic              do_switch;
    logic              go_idle;
    logic              restart;
    logic [CH_NUM-1:0] shown_mask;
    logic [CH_NUM-1:0] nxt_mask;
    logic [CH_NUM-1:0] pend_set;
    logic [CH_NUM-1:0] pend_clr;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            ch_data[i] = ch_data_in[8*i +: 8];
        end
    end

    // In IDLE the search starts as if the last channel were shown,
    // so channel 0 is the first rotation candidate.
    assign cur    = (state == SHOW) ? ch_sel_out : LAST_CH;
    assign cand   = pending & ch_en_in;
    assign any_en = |ch_en_in;

    // Pending updates win (lowest index), else next enabled after cur.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!found && cand[i] && SEL_W'(i) != cur) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
        for (int k = 1; k < CH_NUM; k++) begin
            idx = SEL_W'((int'(cur) + k) % CH_NUM);
            if (!found && ch_en_in[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        do_switch = 1'b0;
        go_idle   = 1'b0;
        restart   = 1'b0;
        if (state == IDLE) begin
            do_switch = any_en;
        end else if (!ch_en_in[ch_sel_out]) begin
            do_switch = any_en;
            go_idle   = !any_en;
        end else if (|cand && dwell_cnt >= MIN_LAST) begin
            do_switch = 1'b1;
        end else if (dwell_cnt == DWELL_LAST) begin
            // Sole enabled channel: restart the dwell silently.
            do_switch = (nxt != ch_sel_out);
            restart   = (nxt == ch_sel_out);
        end else begin
            restart = ch_upd_in[ch_sel_out];
        end
    end

    assign shown_mask = (state == SHOW) ? (CH_NUM'(1) << ch_sel_out) : '0;
    assign nxt_mask   = do_switch ? (CH_NUM'(1) << nxt) : '0;
    assign pend_set   = ch_upd_in & ch_en_in & ~shown_mask;
    assign pend_clr   = ~ch_en_in | nxt_mask;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            dwell_cnt  <= '0;
            pending    <= '0;
            count_out  <= '0;
            ch_sel_out <= '0;
            valid_out  <= 1'b0;
            switch_out <= 1'b0;
        end else begin
            pending    <= (pending | pend_set) & ~pend_clr;
            switch_out <= do_switch;
            if (do_switch) begin
                state      <= SHOW;
                ch_sel_out <= nxt;
                count_out  <= ch_data[nxt];
                dwell_cnt  <= '0;
                valid_out  <= 1'b1;
            end else if (state == IDLE) begin
                valid_out <= 1'b0;
                count_out <= '0;
            end else if (go_idle) begin
                // Outputs hold for this one cycle, then IDLE blanks them.
                state     <= IDLE;
                dwell_cnt <= '0;
            end else begin
                count_out <= ch_data[ch_sel_out];
                dwell_cnt <= restart ? '0 : dwell_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/segment_display_sched.md
# segment_display_sched

Time-shares the two-digit segment display between up to CH_NUM 8-bit count sources. Each source is a channel with an enable and an update strobe. The block rotates round-robin through enabled channels with a fixed dwell time, and lets a freshly updated channel pre-empt after a minimum dwell. Its registered `count_out` and `ch_sel_out` drive the existing `segment_led` decoder's `count` input and a channel-indicator LED.

## Interface
- CH_NUM, 4: number of channels, 2..16.
- DWELL_CYCLES, 12_000_000: cycles each channel is shown in normal rotation, ≥ 2.
- MIN_DWELL, 3_000_000: minimum cycles shown before a pending update may pre-empt, 1 ≤ MIN_DWELL ≤ DWELL_CYCLES.
- SEL_W, $clog2(CH_NUM): width of the channel index (local).
- clk_in  in  1  system clock. One clock; reset is asynchronous and active-high.
- rst_in  in  1  asynchronous, active-high reset.
- ch_en_in  in  CH_NUM  per-channel enable (level).
- ch_data_in  in  8*CH_NUM  channel i value at bits [8i+7:8i].
- ch_upd_in  in  CH_NUM  one-cycle update strobe per channel.
- count_out  out  8  value for the display.
- ch_sel_out  out  SEL_W  index of the channel shown.
- valid_out  out  1  high while a channel is shown (blank display when low).
- switch_out  out  1  one-cycle pulse when the shown channel changes.

## Operation
- Reset values: count_out=0, ch_sel_out=0, valid_out=0, switch_out=0, pending=0, dwell_cnt=0, state=IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States are IDLE and SHOW.
- **IDLE**
  - valid_out=0 and count_out=0.
  - When ch_en_in≠0, the next edge enters SHOW with the selected channel, following the selection rule with "current" treated as index CH_NUM-1.
- **SHOW**
  - Every cycle: count_out <= ch_data_in[sel], so live data has 1-cycle latency. dwell_cnt increments.
- **Switch event**
  - Happens on one edge.
  - ch_sel_out <= next, count_out <= ch_data_in[next], dwell_cnt <= 0, switch_out <= 1, pending[next] <= 0.
- **Next-channel selection rule**
  1. Lowest-index channel with pending & ch_en_in, excluding the current channel.
  2. Otherwise, the first enabled channel after the current one, wrapping modulo CH_NUM.
  3. Otherwise, the current channel.
- **Switch triggers, evaluated each SHOW cycle in priority order**
  1. ch_en_in[sel]=0: switch immediately to next. If no channel is enabled, go to IDLE; valid_out, count_out and ch_sel_out keep their last values for one cycle, then valid_out=0 and count_out=0.
  2. Any pending bit set and dwell_cnt ≥ MIN_DWELL-1: pre-empt to next.
  3. dwell_cnt = DWELL_CYCLES-1: rotate to next. If next equals the current channel, restart dwell_cnt and do not pulse switch_out.
- **pending[i]**
  - Set by ch_upd_in[i] & ch_en_in[i] unless i is the channel currently shown in SHOW.
  - Cleared when i is switched to, or when ch_en_in[i]=0. Clear wins over a simultaneous set.
- **ch_upd_in[sel] while showing sel:** restarts dwell_cnt to 0 and sets no pending bit.
- dwell_cnt is wide enough for DWELL_CYCLES-1 and never wraps, because a trigger always fires first.
- Asynchronous reset mid-dwell returns everything to reset values immediately.

## Timing
- IDLE to SHOW: the first edge after ch_en_in becomes nonzero. valid_out and switch_out rise on that edge.
- Normal rotation: each channel is shown for exactly DWELL_CYCLES cycles, measured between switch_out pulses.
- Pre-emption: the earliest switch comes MIN_DWELL cycles after the current channel was selected. A strobe arriving later pre-empts on the edge after the strobe cycle (pending registers first).
- Data change on the shown channel: appears on count_out 1 cycle later.
- switch_out is exactly 1 cycle wide. It is never asserted in IDLE.

## Test plan
Use CH_NUM=4, DWELL_CYCLES=8, MIN_DWELL=3.
- **Reset and IDLE:** release rst_in with ch_en_in=0 for 20 cycles → all outputs 0, no switch_out.
- **Rotation:** ch_en_in=4'b1011, data = 10, 20, 30, 40.
  - Sequence is sel 0,1,3,0,… with count_out 10, 20, 40, 10.
  - switch_out pulses every 8 cycles; channel 2 is never shown.
- **Pre-emption:** showing ch0, strobe ch_upd_in[2] at dwell_cnt=0.
  - Switch to ch2 occurs at dwell_cnt=2, i.e. 3 cycles after selection.
  - Then rotation resumes 2 → 3 → 0.
- **Simultaneous pending:** strobe ch3 and ch1 in the same cycle while showing ch0 → ch1 is shown first, then ch3 by pre-emption after 3 cycles.
- **Disable mid-dwell:**
  - Drop ch_en_in[sel] at dwell_cnt=4 → switch on the next edge.
  - Drop all enables → valid_out=0 and count_out=0 two edges later.
  - Re-enable ch2 → next edge shows ch2.
- **Single channel and self-update:** only ch1 enabled, data 255.
  - count_out=255 continuously; switch_out pulses only once (on entry).
  - Strobing ch_upd_in[1] at dwell_cnt=6 restarts the dwell with no switch.
  - Changing data to 7 shows 7 one cycle later.
  - Asserting rst_in mid-dwell zeroes outputs immediately.
